// File: rtl/cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_ctrl_pkg
// Purpose  : Shared definitions for the cycle_ctrl_v2 instruction-cycle
//            controller: 3-bit base opcodes, the FSM state encoding,
//            one-hot phase constants and the ALU/LDA opcode classifier.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cycle_ctrl_pkg;

  // Base 8-op accumulator ISA, carried in the low three opcode bits.
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_S1     = 4'd1,
    ST_S2     = 4'd2,
    ST_S3     = 4'd3,
    ST_S4     = 4'd4,
    ST_S5     = 4'd5,
    ST_S6     = 4'd6,
    ST_S7     = 4'd7,
    ST_S8     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

  // One-hot phase codes presented on the state output (bit0 = S1).
  localparam logic [7:0] PH_NONE = 8'h00;
  localparam logic [7:0] PH_S1   = 8'h01;
  localparam logic [7:0] PH_S2   = 8'h02;
  localparam logic [7:0] PH_S3   = 8'h04;
  localparam logic [7:0] PH_S4   = 8'h08;
  localparam logic [7:0] PH_S5   = 8'h10;
  localparam logic [7:0] PH_S6   = 8'h20;
  localparam logic [7:0] PH_S7   = 8'h40;
  localparam logic [7:0] PH_S8   = 8'h80;

  // Opcodes that read an operand from memory in S5..S7 and load the ACC in S6.
  function automatic logic is_alu_lda(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_ctrl_v2_mem_wait_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_watchdog
// Purpose  : Counts consecutive stalled cycles of one memory phase and flags
//            a timeout on the stalled cycle where the count reaches WAIT_MAX.
//            The error flag is sticky until reset.
// Ports    : clk, rst_n        clock / async active-low reset
//            stall_i           current cycle is a stalled memory phase
//            timeout_o         comb: this stalled cycle exceeds the budget
//            err_timeout_o     registered sticky timeout flag
// Params   : WAIT_MAX          stalled cycles tolerated per phase
// Revision : 1.0  initial release
// ============================================================================
module mem_wait_watchdog #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  output logic timeout_o,
  output logic err_timeout_o
);

  // At least one bit so WAIT_MAX = 0 still yields a legal counter.
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  assign timeout_o = stall_i && (wait_cnt_q == C_LIMIT);

  // Any non-stalled cycle is a phase change (or an idle state), which
  // restarts the count; a timeout also leaves the phase, so clear there too.
  always_comb begin
    wait_cnt_d = '0;
    err_d      = err_q | timeout_o;
    if (stall_i && !timeout_o) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout_o = err_q;

endmodule
`default_nettype wire

// File: rtl/cycle_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : cycle_ctrl_v2
// Purpose  : Eight-phase fetch/decode/execute controller for the 8-op
//            accumulator ISA with illegal-op detection, memory wait states,
//            a stall watchdog and a resumable HALTED state.
// Ports    : clk, rst_n            clock / async active-low reset
//            start_i               level; leaves IDLE / HALTED
//            opcode_i[OP_W]        opcode from IR (latched at end of S3)
//            zero_i                accumulator == 0 (latched at end of S5)
//            mem_ready_i           memory completes the access this cycle
//            step_mode_i           (CTRL_SINGLE_STEP_EN only) halt after S8
//            pc_inc_o, load_ir_o, load_pc_o, load_acc_o   one-shot strobes
//            rd_o, wr_o, data_en_o                        level signals
//            halt_o, busy_o        HALTED / S1..S8 indicators
//            illegal_op_o          S4 pulse for an opcode above 7
//            err_timeout_o         sticky memory timeout flag
//            state_o[8]            one-hot phase, 0 in IDLE / HALTED
// Macro    : CTRL_SINGLE_STEP_EN adds step_mode_i
// Revision : 1.0  initial release
// ============================================================================
module cycle_ctrl_v2
  import cycle_ctrl_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step_mode_i,
`endif
  input  logic            start_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_inc_o,
  output logic            rd_o,
  output logic            wr_o,
  output logic            load_acc_o,
  output logic            load_ir_o,
  output logic            load_pc_o,
  output logic            data_en_o,
  output logic            halt_o,
  output logic            busy_o,
  output logic            illegal_op_o,
  output logic            err_timeout_o,
  output logic [7:0]      state_o
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            zero_q, zero_d;

  logic [2:0] w_op3;
  logic       w_legal, w_alu, w_sto, w_jmp, w_skz, w_hlt;
  logic       w_busy, w_mem_phase, w_advance, w_stall, w_timeout, w_step;

`ifdef CTRL_SINGLE_STEP_EN
  assign w_step = step_mode_i;
`else
  assign w_step = 1'b0;
`endif

  // Opcodes above 7 are illegal and decode as a no-op: every class flag
  // below is qualified by w_legal so the low bits alone never act.
  assign w_op3   = op_q[2:0];
  assign w_legal = ((op_q >> 3) == '0);
  assign w_alu   = w_legal && is_alu_lda(w_op3);
  assign w_sto   = w_legal && (w_op3 == OP_STO);
  assign w_jmp   = w_legal && (w_op3 == OP_JMP);
  assign w_skz   = w_legal && (w_op3 == OP_SKZ);
  assign w_hlt   = w_legal && (w_op3 == OP_HLT);

  assign w_busy = (state_q != ST_IDLE) && (state_q != ST_HALTED);

  always_comb begin
    w_mem_phase = 1'b0;
    case (state_q)
      ST_S1, ST_S2: w_mem_phase = 1'b1;
      ST_S5, ST_S7: w_mem_phase = w_alu;
      ST_S6:        w_mem_phase = w_alu | w_sto;
      default:      w_mem_phase = 1'b0;
    endcase
  end

  assign w_advance = w_mem_phase ? mem_ready_i : 1'b1;
  assign w_stall   = w_mem_phase && !mem_ready_i;

  mem_wait_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (w_stall),
    .timeout_o     (w_timeout),
    .err_timeout_o (err_timeout_o)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start_i) state_d = ST_S1;
      end
      default: begin
        if (w_timeout) begin
          state_d = ST_HALTED;
        end else if (w_advance) begin
          case (state_q)
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = ST_S4;
            ST_S4:   state_d = w_hlt  ? ST_HALTED : ST_S5;
            ST_S5:   state_d = ST_S6;
            ST_S6:   state_d = ST_S7;
            ST_S7:   state_d = ST_S8;
            ST_S8:   state_d = w_step ? ST_HALTED : ST_S1;
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // Operand latches: opcode on leaving S3 (always a single cycle), zero
  // flag on leaving S5 (which may stall for ALU/LDA operand reads).
  assign op_d   = (state_q == ST_S3) ? opcode_i : op_q;
  assign zero_d = ((state_q == ST_S5) && w_advance) ? zero_i : zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  // Output decode. Strobes are qualified by w_advance so a stalled phase
  // produces them only on its completing cycle.
  always_comb begin
    pc_inc_o     = 1'b0;
    rd_o         = 1'b0;
    wr_o         = 1'b0;
    load_acc_o   = 1'b0;
    load_ir_o    = 1'b0;
    load_pc_o    = 1'b0;
    data_en_o    = 1'b0;
    illegal_op_o = 1'b0;
    state_o      = PH_NONE;
    case (state_q)
      ST_S1: begin
        state_o   = PH_S1;
        rd_o      = 1'b1;
        load_ir_o = w_advance;
      end
      ST_S2: begin
        state_o   = PH_S2;
        rd_o      = 1'b1;
        load_ir_o = w_advance;
        pc_inc_o  = w_advance;
      end
      ST_S3: begin
        state_o = PH_S3;
      end
      ST_S4: begin
        state_o      = PH_S4;
        pc_inc_o     = 1'b1;
        illegal_op_o = !w_legal;
      end
      ST_S5: begin
        state_o   = PH_S5;
        load_pc_o = w_jmp;
        rd_o      = w_alu;
        data_en_o = w_sto;
      end
      ST_S6: begin
        state_o    = PH_S6;
        rd_o       = w_alu;
        load_acc_o = w_alu & w_advance;
        pc_inc_o   = (w_skz & zero_q) | w_jmp;
        load_pc_o  = w_jmp;
        wr_o       = w_sto;
        data_en_o  = w_sto;
      end
      ST_S7: begin
        state_o   = PH_S7;
        rd_o      = w_alu;
        data_en_o = w_sto;
      end
      ST_S8: begin
        state_o  = PH_S8;
        pc_inc_o = w_skz & zero_q;
      end
      default: begin
        state_o = PH_NONE;
      end
    endcase
  end

  assign halt_o = (state_q == ST_HALTED);
  assign busy_o = w_busy;

endmodule
`default_nettype wire
